gat_bram_load_bridge: RTL and testbench

- Parametrised, multi-channel bridge between the PS-side 32-bit byte-addressed BRAM-controller ports and the narrow word-addressed BRAMs inside the GAT core.
- Successor to the fixed per-BRAM slicing wrapper. Adds:
  - per-channel registered address/data conversion;
  - write counting with hardware-generated load_done per channel (no longer driven by software);
  - sticky range and alignment error flags;
  - a latency-matched, valid-tagged readback path for the feature BRAM.

---
 rtl/gat_pkg.sv | 18 +
 rtl/gat_bram_load_ch.sv | 106 ++++++++++
 rtl/gat_bram_load_bridge.sv | 93 +++++++++
 tb/tb_gat_bram_load_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared constants and FSM state type for the GAT BRAM load bridge.
// Channel indices follow the order of the PS-side BRAM controller ports.
package gat_pkg;

  localparam int CH_H_DATA    = 0;
  localparam int CH_NODE_INFO = 1;
  localparam int CH_WGT       = 2;
  localparam int CH_SUBGRAPH  = 3;

  localparam int BYTE_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/gat_bram_load_ch.sv
// One write channel: checks each PS write, registers it onto the core port,
// and counts accepted writes against the armed length to raise load_done.
module gat_bram_load_ch
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH   = 32,
  parameter int CORE_DATA_W = 20,
  parameter int DEPTH       = 242101,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TOP_WIDTH-1:0]   din,
  input  logic                   ena,
  input  logic                   wea,
  input  logic [ADDR_W+1:0]      addra,
  input  logic                   cfg_start,
  input  logic [ADDR_W:0]        cfg_len,
  output logic [CORE_DATA_W-1:0] core_din,
  output logic                   core_ena,
  output logic                   core_wea,
  output logic [ADDR_W-1:0]      core_addra,
  output logic                   load_done,
  output logic                   err_oob,
  output logic                   err_unaligned,
  output logic                   err_overrun,
  output logic [1:0]             dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  load_state_e       state, state_d;
  logic [ADDR_W:0]   cnt, cnt_d;
  logic [ADDR_W:0]   len, len_d;
  logic [ADDR_W-1:0] word;
  logic              wr, unaligned, oob, accept, fwd;
  logic              unused_din;

  assign unused_din = ^din[TOP_WIDTH-1:CORE_DATA_W];
  assign word       = addra[ADDR_W+1:BYTE_SHIFT];
  assign wr         = ena & wea;
  assign unaligned  = (addra[BYTE_SHIFT-1:0] != '0);
  assign oob        = ({1'b0, word} >= DEPTH_W);
  assign accept     = wr & ~unaligned & ~oob;
  // A dropped write produces no core access at all; plain reads pass through.
  assign fwd        = ena & (~wea | accept);
  assign dbg_state  = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    len_d   = len;
    if (cfg_start) begin
      len_d   = cfg_len;
      cnt_d   = '0;
      state_d = (cfg_len == '0) ? ST_DONE : ST_LOAD;
    end else if (state == ST_LOAD && accept) begin
      cnt_d = cnt + 1'b1;
      if (cnt + 1'b1 == len) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      len   <= len_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_din      <= '0;
      core_ena      <= 1'b0;
      core_wea      <= 1'b0;
      core_addra    <= '0;
      load_done     <= 1'b0;
      err_oob       <= 1'b0;
      err_unaligned <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      core_ena <= fwd;
      core_wea <= accept;
      if (fwd) begin
        core_addra <= word;
        core_din   <= din[CORE_DATA_W-1:0];
      end
      // Registered from the current state so it trails the final strobe by a cycle.
      load_done <= (state == ST_DONE) & ~cfg_start;
      if (cfg_start) begin
        err_oob       <= 1'b0;
        err_unaligned <= 1'b0;
        err_overrun   <= 1'b0;
      end else begin
        err_oob       <= err_oob | (wr & oob);
        err_unaligned <= err_unaligned | (wr & unaligned);
        err_overrun   <= err_overrun | (accept & (state == ST_DONE));
      end
    end
  end

endmodule

// File: rtl/gat_bram_load_bridge.sv
// PS-to-core BRAM bridge: NUM_CH checked write channels with load tracking,
// plus a latency-matched, valid-tagged readback path for the feature BRAM.
module gat_bram_load_bridge
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH   = 32,
  parameter int NUM_CH      = 4,
  parameter int CORE_DATA_W = 20,
  parameter int DEPTH       = 242101,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int RD_ADDR_W   = 14,
  parameter int RD_DATA_W   = 32,
  parameter int RD_LAT      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*TOP_WIDTH-1:0]   bram_din,
  input  logic [NUM_CH-1:0]             bram_ena,
  input  logic [NUM_CH-1:0]             bram_wea,
  input  logic [NUM_CH*(ADDR_W+2)-1:0]  bram_addra,
  input  logic [NUM_CH-1:0]             cfg_start,
  input  logic [NUM_CH*(ADDR_W+1)-1:0]  cfg_len,
  output logic [NUM_CH*CORE_DATA_W-1:0] core_din,
  output logic [NUM_CH-1:0]             core_ena,
  output logic [NUM_CH-1:0]             core_wea,
  output logic [NUM_CH*ADDR_W-1:0]      core_addra,
  output logic [NUM_CH-1:0]             load_done,
  output logic                          all_load_done,
  output logic [NUM_CH-1:0]             err_oob,
  output logic [NUM_CH-1:0]             err_unaligned,
  output logic [NUM_CH-1:0]             err_overrun,
  input  logic                          rd_en,
  input  logic [RD_ADDR_W+1:0]          rd_addr,
  output logic [RD_ADDR_W-1:0]          core_rd_addr,
  input  logic [RD_DATA_W-1:0]          core_rd_dout,
  output logic                          rd_valid,
  output logic [TOP_WIDTH-1:0]          rd_dout,
  output logic [NUM_CH*2-1:0]           dbg_state
);

  logic [RD_LAT:0] rd_pipe;
  logic            unused_rd_addr;

  assign unused_rd_addr = ^rd_addr[BYTE_SHIFT-1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_bram_load_ch #(
      .TOP_WIDTH  (TOP_WIDTH),
      .CORE_DATA_W(CORE_DATA_W),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .din          (bram_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .ena          (bram_ena[c]),
      .wea          (bram_wea[c]),
      .addra        (bram_addra[c*(ADDR_W+2) +: ADDR_W+2]),
      .cfg_start    (cfg_start[c]),
      .cfg_len      (cfg_len[c*(ADDR_W+1) +: ADDR_W+1]),
      .core_din     (core_din[c*CORE_DATA_W +: CORE_DATA_W]),
      .core_ena     (core_ena[c]),
      .core_wea     (core_wea[c]),
      .core_addra   (core_addra[c*ADDR_W +: ADDR_W]),
      .load_done    (load_done[c]),
      .err_oob      (err_oob[c]),
      .err_unaligned(err_unaligned[c]),
      .err_overrun  (err_overrun[c]),
      .dbg_state    (dbg_state[c*2 +: 2])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_load_done <= 1'b0;
    else        all_load_done <= &load_done;
  end

  // rd_pipe[0] marks the address cycle; rd_pipe[RD_LAT] marks BRAM data on core_rd_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rd_addr <= '0;
      rd_pipe      <= '0;
      rd_valid     <= 1'b0;
      rd_dout      <= '0;
    end else begin
      if (rd_en) core_rd_addr <= rd_addr[RD_ADDR_W+1:BYTE_SHIFT];
      rd_pipe  <= {rd_pipe[RD_LAT-1:0], rd_en};
      rd_valid <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT]) rd_dout <= TOP_WIDTH'(core_rd_dout);
    end
  end

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Self-checking bench for gat_bram_load_bridge: write scoreboard, vector
// table for acceptance rules, and directed multi-cycle sequences.
module tb_gat_bram_load_bridge;

  localparam int TOP_WIDTH   = 32;
  localparam int NUM_CH      = 4;
  localparam int CORE_DATA_W = 20;
  localparam int DEPTH       = 242101;
  localparam int ADDR_W      = $clog2(DEPTH);
  localparam int RD_ADDR_W   = 14;
  localparam int RD_DATA_W   = 32;
  localparam int RD_LAT      = 2;
  localparam int AW2         = ADDR_W + 2;
  localparam int LW          = ADDR_W + 1;
  localparam int WQ_W        = 2 + ADDR_W + CORE_DATA_W;

  // Handshake: every core access is a single-cycle strobe one cycle after the
  // PS write; rd_valid qualifies rd_dout for exactly one cycle per request.

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_CH*TOP_WIDTH-1:0]   bram_din;
  logic [NUM_CH-1:0]             bram_ena;
  logic [NUM_CH-1:0]             bram_wea;
  logic [NUM_CH*AW2-1:0]         bram_addra;
  logic [NUM_CH-1:0]             cfg_start;
  logic [NUM_CH*LW-1:0]          cfg_len;
  logic [NUM_CH*CORE_DATA_W-1:0] core_din;
  logic [NUM_CH-1:0]             core_ena;
  logic [NUM_CH-1:0]             core_wea;
  logic [NUM_CH*ADDR_W-1:0]      core_addra;
  logic [NUM_CH-1:0]             load_done;
  logic                          all_load_done;
  logic [NUM_CH-1:0]             err_oob;
  logic [NUM_CH-1:0]             err_unaligned;
  logic [NUM_CH-1:0]             err_overrun;
  logic                          rd_en;
  logic [RD_ADDR_W+1:0]          rd_addr;
  logic [RD_ADDR_W-1:0]          core_rd_addr;
  logic [RD_DATA_W-1:0]          core_rd_dout;
  logic                          rd_valid;
  logic [TOP_WIDTH-1:0]          rd_dout;
  logic [NUM_CH*2-1:0]           dbg_state;

  gat_bram_load_bridge #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .CORE_DATA_W(CORE_DATA_W),
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_ADDR_W(RD_ADDR_W),
    .RD_DATA_W(RD_DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bram_din(bram_din), .bram_ena(bram_ena),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .cfg_start(cfg_start),
    .cfg_len(cfg_len), .core_din(core_din), .core_ena(core_ena),
    .core_wea(core_wea), .core_addra(core_addra), .load_done(load_done),
    .all_load_done(all_load_done), .err_oob(err_oob),
    .err_unaligned(err_unaligned), .err_overrun(err_overrun), .rd_en(rd_en),
    .rd_addr(rd_addr), .core_rd_addr(core_rd_addr),
    .core_rd_dout(core_rd_dout), .rd_valid(rd_valid), .rd_dout(rd_dout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- feature BRAM model (2-cycle read) ----------------
  function automatic logic [31:0] feat(input logic [RD_ADDR_W-1:0] w);
    return 32'hA500_0000 + 32'(w) * 32'h0000_1111;
  endfunction

  logic [31:0] fb_s1, fb_s2;
  always @(posedge clk) begin
    fb_s1 <= feat(core_rd_addr);
    fb_s2 <= fb_s1;
  end
  assign core_rd_dout = fb_s2;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [WQ_W-1:0] exp_q[$];
  logic [63:0]     rd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (core_wea[c]) begin
          chk("core_ena_with_wea", 64'(core_ena[c]), 64'd1);
          if (exp_q.size() == 0) chk("unexpected_core_wea", 64'(c), 64'hFF);
          else chk("core_write", 64'({2'(c), core_addra[c*ADDR_W +: ADDR_W],
                                      core_din[c*CORE_DATA_W +: CORE_DATA_W]}),
                   64'(exp_q.pop_front()));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rd_valid", 64'(rd_dout), 64'hFFFF_FFFF_FFFF);
        else begin
          logic [63:0] e;
          e = rd_q.pop_front();
          chk("rd_latency", 64'(cyc), 64'(e[63:32]));
          chk("rd_dout", 64'(rd_dout), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bram_ena  = '0;
    bram_wea  = '0;
    cfg_start = '0;
    rd_en     = 1'b0;
  endtask

  task automatic set_wr(input int c, input logic [AW2-1:0] a, input logic [31:0] d);
    bram_ena[c] = 1'b1;
    bram_wea[c] = 1'b1;
    bram_addra[c*AW2 +: AW2] = a;
    bram_din[c*TOP_WIDTH +: TOP_WIDTH] = d;
    if (a[1:0] == 2'b00 && int'(a >> 2) < DEPTH)
      exp_q.push_back({2'(c), a[AW2-1:2], d[CORE_DATA_W-1:0]});
  endtask

  task automatic wr1(input int c, input logic [AW2-1:0] a, input logic [31:0] d);
    set_wr(c, a, d);
    tick();
    idle_in();
  endtask

  task automatic arm(input int c, input int len);
    cfg_start[c] = 1'b1;
    cfg_len[c*LW +: LW] = LW'(len);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW2-1:0] addr;
    logic [31:0]    din;
    logic           wea;
    logic           exp_ena;
    logic           exp_wea;
    logic           exp_unal;
    logic           exp_oob;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{AW2'(32'h10),          32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{AW2'(32'h0),           32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{AW2'(32'h6),           32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{AW2'(4*(DEPTH-1)),     32'h000F_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{AW2'(4*DEPTH),         32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{AW2'(32'hF_FFFF),      32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{AW2'(32'h3),           32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    bram_din = '0; bram_addra = '0; cfg_len = '0; rd_addr = '0;
    idle_in();
    repeat (3) tick();

    // Reset state
    chk("rst_core_wea", 64'(core_wea), 64'd0);
    chk("rst_core_ena", 64'(core_ena), 64'd0);
    chk("rst_load_done", 64'({all_load_done, load_done}), 64'd0);
    chk("rst_errs", 64'({err_oob, err_unaligned, err_overrun}), 64'd0);
    chk("rst_rd", 64'({rd_valid, rd_dout, core_rd_addr}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // Acceptance rules on channel 3 while IDLE (sticky flags are cumulative)
    for (int i = 0; i < 7; i++) begin
      bram_ena[3] = 1'b1;
      if (vecs[i].wea) set_wr(3, vecs[i].addr, vecs[i].din);
      else bram_addra[3*AW2 +: AW2] = vecs[i].addr;
      tick();
      chk("vec_core_ena", 64'(core_ena[3]), 64'(vecs[i].exp_ena));
      chk("vec_core_wea", 64'(core_wea[3]), 64'(vecs[i].exp_wea));
      chk("vec_err_unaligned", 64'(err_unaligned[3]), 64'(vecs[i].exp_unal));
      chk("vec_err_oob", 64'(err_oob[3]), 64'(vecs[i].exp_oob));
      idle_in();
    end
    chk("idle_no_count", 64'(load_done[3]), 64'd0);

    // Channel 0 load of 3 words
    arm(0, 3); tick(); idle_in();
    chk("ch0_state_load", 64'(dbg_state[1:0]), 64'd1);
    wr1(0, AW2'(32'h0), 32'hFFF1_2345);
    chk("ch0_ld_after1", 64'(load_done[0]), 64'd0);
    wr1(0, AW2'(32'h4), 32'hFFF1_2345);
    wr1(0, AW2'(32'h8), 32'hFFF1_2345);
    chk("ch0_addr2", 64'(core_addra[ADDR_W-1:0]), 64'd2);
    chk("ch0_din", 64'(core_din[CORE_DATA_W-1:0]), 64'h12345);
    chk("ch0_ld_with_strobe", 64'(load_done[0]), 64'd0);
    tick();
    chk("ch0_ld_rise", 64'(load_done[0]), 64'd1);
    chk("ch0_all_low", 64'(all_load_done), 64'd0);

    // All channels, len=2, interleaved
    for (int c = 0; c < NUM_CH; c++) arm(c, 2);
    tick(); idle_in();
    chk("arm_clears_done", 64'(load_done), 64'd0);
    set_wr(0, AW2'(32'h100), 32'h0000_0A0A); set_wr(1, AW2'(32'h100), 32'h0000_0B0B);
    tick(); idle_in();
    set_wr(2, AW2'(32'h200), 32'h0000_0C0C); set_wr(3, AW2'(32'h300), 32'h0000_0D0D);
    tick(); idle_in();
    set_wr(0, AW2'(32'h104), 32'h0001_1111); set_wr(2, AW2'(32'h204), 32'h0002_2222);
    tick(); idle_in();
    set_wr(1, AW2'(32'h104), 32'h0003_3333); set_wr(3, AW2'(32'h304), 32'h0004_4444);
    tick(); idle_in();
    chk("il_partial_done", 64'(load_done), 64'b0101);
    tick();
    chk("il_all_done_bits", 64'(load_done), 64'hF);
    chk("il_all_lags", 64'(all_load_done), 64'd0);
    tick();
    chk("il_all_rise", 64'(all_load_done), 64'd1);

    // Dropped writes do not count
    arm(2, 2); tick(); idle_in();
    wr1(2, AW2'(32'h6), 32'h1);
    chk("drop_unal", 64'(err_unaligned[2]), 64'd1);
    wr1(2, AW2'(4*DEPTH), 32'h2);
    chk("drop_oob", 64'(err_oob[2]), 64'd1);
    wr1(2, AW2'(32'h20), 32'h3);
    tick();
    chk("drop_not_counted", 64'(load_done[2]), 64'd0);
    wr1(2, AW2'(32'h24), 32'h4);
    tick();
    chk("drop_then_done", 64'(load_done[2]), 64'd1);

    // Overrun on channel 1, cleared by re-arm
    arm(1, 1); tick(); idle_in();
    wr1(1, AW2'(32'h0), 32'h5);
    chk("ovr_none_yet", 64'(err_overrun[1]), 64'd0);
    wr1(1, AW2'(32'h4), 32'h6);
    chk("ovr_set", 64'(err_overrun[1]), 64'd1);
    arm(1, 1); tick(); idle_in();
    chk("ovr_cleared", 64'({err_overrun[1], load_done[1]}), 64'd0);
    // Arm and write in the same cycle: write forwarded, not counted
    arm(1, 1); set_wr(1, AW2'(32'h8), 32'h7); tick(); idle_in();
    tick();
    chk("arm_wins", 64'(load_done[1]), 64'd0);
    wr1(1, AW2'(32'hC), 32'h8);
    tick();
    chk("arm_wins_done", 64'(load_done[1]), 64'd1);

    // Zero length goes straight to DONE
    arm(0, 0); tick(); idle_in();
    chk("len0_state", 64'(dbg_state[1:0]), 64'd2);
    chk("len0_ld_lag", 64'(load_done[0]), 64'd0);
    tick();
    chk("len0_ld", 64'(load_done[0]), 64'd1);

    // Readback, three back-to-back requests
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      rd_addr = (RD_ADDR_W+2)'(i * 4);
      rd_q.push_back({32'(cyc + RD_LAT + 2), feat(RD_ADDR_W'(i))});
      tick();
      chk("core_rd_addr", 64'(core_rd_addr), 64'(i));
    end
    idle_in();
    repeat (6) tick();
    chk("rd_valid_idle", 64'(rd_valid), 64'd0);
    chk("rd_dout_hold", 64'(rd_dout), 64'(feat(RD_ADDR_W'(2))));

    // Asynchronous reset in the middle of a load
    wr1(0, AW2'(32'h6), 32'h9);
    arm(2, 8); tick(); idle_in();
    for (int i = 0; i < 5; i++) wr1(2, AW2'(i * 4), 32'(i));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_core", 64'({core_wea, core_ena, core_addra}), 64'd0);
    chk("mid_rst_din", 64'(core_din), 64'd0);
    chk("mid_rst_done", 64'({all_load_done, load_done}), 64'd0);
    chk("mid_rst_errs", 64'({err_oob, err_unaligned, err_overrun}), 64'd0);
    chk("mid_rst_rd", 64'({rd_valid, rd_dout, core_rd_addr}), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) wr1(2, AW2'(i * 4), 32'(i + 16));
    tick();
    chk("post_rst_idle", 64'({dbg_state[5:4], load_done[2]}), 64'd0);
    arm(2, 1); tick(); idle_in();
    wr1(2, AW2'(32'h40), 32'hABCDE);
    tick();
    chk("post_rst_load", 64'(load_done[2]), 64'd1);

    repeat (4) tick();
    chk("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
